// File: rtl/btn_scan.sv
// btn_scan: N-channel debouncer (TICK=sample strobe every DIV CLKs; IN raw, LEVEL debounced, PRESS/RELEASE one-CLK pulses; RST sync active-high), auto-repeat under BTN_SCAN_REPEAT_EN
module btn_scan #(
  parameter int N = 4,
  parameter int DIV = 1250000,
  parameter int STABLE = 2,
  parameter logic [N-1:0] ACT_LOW = '1,
  parameter int REP_DLY = 20,
  parameter int REP_RATE = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] IN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic         TICK
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] STOP = SW'(STABLE - 1);
  logic [DW-1:0] cnt, cnt_nxt;
  logic [N-1:0] s1, s2, x;
  assign cnt_nxt = cnt == LAST ? '0 : cnt + 1'b1;
  assign x = s2 ^ ACT_LOW;
  always_ff @(posedge CLK)
    if (RST) begin
      cnt <= '0;
      TICK <= 1'b0;
      s1 <= ACT_LOW;
      s2 <= ACT_LOW;
    end else begin
      cnt <= cnt_nxt;
      TICK <= cnt_nxt == LAST;
      s1 <= IN;
      s2 <= s1;
    end
`ifdef BTN_SCAN_REPEAT_EN
  localparam int RMAX = REP_DLY > REP_RATE ? REP_DLY : REP_RATE;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
`endif
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SW-1:0] sc;
    logic lv, pr, rl, flip, rep_hit;
    assign flip = TICK && x[i] != lv && sc == STOP;
`ifdef BTN_SCAN_REPEAT_EN
    logic [RW-1:0] rc;
    logic rep;
    assign rep_hit = TICK && lv && !flip && rc == (rep ? RW'(REP_RATE - 1) : RW'(REP_DLY - 1));
    always_ff @(posedge CLK)
      if (RST || !lv || flip) begin
        rc <= '0;
        rep <= 1'b0;
      end else if (TICK) begin
        rc <= rep_hit ? '0 : rc + 1'b1;
        rep <= rep | rep_hit;
      end
`else
    assign rep_hit = 1'b0;
`endif
    always_ff @(posedge CLK)
      if (RST) begin
        sc <= '0;
        lv <= 1'b0;
        pr <= 1'b0;
        rl <= 1'b0;
      end else begin
        sc <= !TICK ? sc : (x[i] == lv || flip) ? '0 : sc + 1'b1;
        lv <= lv ^ flip;
        pr <= (flip & ~lv) | rep_hit;
        rl <= flip & lv;
      end
    assign LEVEL[i] = lv;
    assign PRESS[i] = pr;
    assign RELEASE[i] = rl;
  end
endmodule

// File: tb/tb_btn_scan.sv
// tb_btn_scan: directed self-checking bench for btn_scan (N=4, DIV=4, STABLE=3, ACT_LOW=0011, REP_DLY=5, REP_RATE=2)
module tb_btn_scan;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] IN = 4'b0011;
  logic [3:0] LEVEL, PRESS, RELEASE;
  logic TICK;
  btn_scan #(.N(4), .DIV(4), .STABLE(3), .ACT_LOW(4'b0011), .REP_DLY(5), .REP_RATE(2)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .TICK(TICK)
  );
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  int cyc = 0;
  int tc = 0, badtick = 0, bad = 0, skew = 0, last_t = -1;
  int pc[4] = '{0, 0, 0, 0};
  int rc[4] = '{0, 0, 0, 0};
  int p2[$];
  logic [3:0] lv_q = 4'b0;
  always @(posedge CLK) cyc++;
  always @(negedge CLK)
    if (RST) begin
      last_t = -1;
      lv_q = 4'b0;
    end else begin
      if (TICK) begin
        tc++;
        if (last_t >= 0 && cyc - last_t != 4) badtick++;
        last_t = cyc;
      end
      for (int i = 0; i < 4; i++) begin
        if (PRESS[i]) begin
          pc[i]++;
          if (!LEVEL[i]) bad++;
`ifndef BTN_SCAN_REPEAT_EN
          if (lv_q[i]) bad++;
`endif
        end
        if (RELEASE[i]) begin
          rc[i]++;
          if (LEVEL[i] || !lv_q[i]) bad++;
        end
        if (LEVEL[i] && !lv_q[i] && !PRESS[i]) bad++;
        if (!LEVEL[i] && lv_q[i] && !RELEASE[i]) bad++;
      end
      if (PRESS[2]) p2.push_back(cyc);
      if (PRESS[1] != PRESS[3] || RELEASE[1] != RELEASE[3]) skew++;
      lv_q = LEVEL;
    end
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int n, s, snap0, snap1, snap3, r1, r3, t0, endc, exp_cnt;
    step(3);
    chk("rst_level", LEVEL, 0);
    chk("rst_press", PRESS, 0);
    chk("rst_release", RELEASE, 0);
    chk("rst_tick", TICK, 0);
    RST = 1'b0;
    step(200);
    chk("idle_ticks", tc, 50);
    chk("idle_tick_gap", badtick, 0);
    chk("idle_level", LEVEL, 0);
    chk("idle_events", pc[0] + pc[1] + pc[2] + pc[3] + rc[0] + rc[1] + rc[2] + rc[3], 0);
    snap0 = pc[2];
    IN[2] = 1'b1;
    n = 0;
    while (!LEVEL[2] && n < 20) begin step(1); n++; end
    chk("press2_latency_ok", n <= 14, 1);
    chk("press2_level", LEVEL[2], 1);
    step(12);
    chk("press2_count", pc[2] - snap0, 1);
    snap0 = rc[2];
    IN[2] = 1'b0;
    n = 0;
    while (LEVEL[2] && n < 20) begin step(1); n++; end
    step(2);
    chk("release2_level", LEVEL[2], 0);
    chk("release2_count", rc[2] - snap0, 1);
    snap0 = pc[0];
    IN[0] = 1'b0;
    step(8);
    IN[0] = 1'b1;
    step(30);
    chk("glitch0_level", LEVEL[0], 0);
    chk("glitch0_press", pc[0] - snap0, 0);
    snap1 = pc[1]; snap3 = pc[3]; r1 = rc[1]; r3 = rc[3];
    IN[1] = 1'b0;
    IN[3] = 1'b1;
    n = 0;
    while (!LEVEL[1] && n < 20) begin step(1); n++; end
    chk("dual_level", LEVEL & 4'b1010, 4'b1010);
    step(10);
    IN[1] = 1'b1;
    IN[3] = 1'b0;
    n = 0;
    while (LEVEL[1] && n < 20) begin step(1); n++; end
    chk("dual_release_level", LEVEL & 4'b1010, 0);
    step(2);
    chk("dual_press_counts", {16'(pc[1] - snap1), 16'(pc[3] - snap3)}, {16'd1, 16'd1});
    chk("dual_release_counts", {16'(rc[1] - r1), 16'(rc[3] - r3)}, {16'd1, 16'd1});
    chk("dual_skew", skew, 0);
    s = p2.size();
    IN[2] = 1'b1;
    step(160);
    endc = cyc;
    n = p2.size() - s;
    t0 = n > 0 ? p2[s] : endc;
`ifdef BTN_SCAN_REPEAT_EN
    exp_cnt = endc >= t0 + 20 ? 2 + (endc - t0 - 20) / 8 : 1;
    for (int j = 1; j < n; j++) chk("repeat_gap", p2[s + j] - p2[s + j - 1], j == 1 ? 20 : 8);
`else
    exp_cnt = 1;
`endif
    chk("repeat_count", n, exp_cnt);
    IN[2] = 1'b0;
    step(30);
    chk("repeat_released", LEVEL[2], 0);
    n = 0;
    while (!TICK && n < 8) begin step(1); n++; end
    chk("tick_found", TICK, 1);
    snap0 = pc[2];
    IN[2] = 1'b1;
    step(9);
    RST = 1'b1;
    step(2);
    chk("rst_mid_no_press", pc[2] - snap0, 0);
    chk("rst_mid_level", LEVEL[2], 0);
    RST = 1'b0;
    step(11);
    chk("post_rst_early", pc[2] - snap0, 0);
    step(1);
    chk("post_rst_press", PRESS[2], 1);
    chk("post_rst_level", LEVEL[2], 1);
    step(2);
    chk("post_rst_count", pc[2] - snap0, 1);
    chk("pulse_coincidence", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
